sdp_ram_responder: RTL and testbench
====================================

# sdp_ram_responder

- Parameterised simple-dual-port RAM: one write port, one read-request port with a fixed-latency, fully pipelined read return.
- Responder end of the `w_*` / `ar_*` / `r_*` memory interface driven by the deep (BRAM-backed) implementation of the team's delay-line shift register. Services one write and one read per cycle with no backpressure.
- Adds configurable read latency, defined read-during-write behaviour and out-of-range address detection.

## Interface
- `WIDTH`, 10: data width in bits.
- `DEPTH`, 64: number of words. Must be at least 2. Address width is `AW = $clog2(DEPTH)`.
- `READ_LATENCY`, 1: cycles from `ar_valid` to `r_valid`. Legal values are 1, 2 and 3.
- `RDW_MODE`, "NEW": read-during-write result when both ports hit the same address in the same cycle. "NEW" returns the write data; "OLD" returns the prior content.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `w_valid`  in  1  write strobe.
- `w_address`  in  AW  write address.
- `w_data`  in  WIDTH  write data.
- `ar_valid`  in  1  read request strobe.
- `ar_address`  in  AW  read address.
- `r_valid`  out  1  read data valid; one pulse per accepted request.
- `r_data`  out  WIDTH  read data.
- `err_addr`  out  1  sticky flag: an out-of-range address was seen on either port.

## Operation
- **Write:** on a rising edge with `w_valid`=1 and `w_address` < `DEPTH`, `mem[w_address] <= w_data`.
- **Out-of-range write:** if `w_address` ≥ `DEPTH`, the write is dropped, memory is unchanged and `err_addr` is set.
- **Read:** every edge with `ar_valid`=1 is accepted; there is no stall and no ready signal.
  - Data is sampled from the array at the accepting edge and carried through a `READ_LATENCY`-deep valid/data pipeline.
  - Later writes to the same address do not alter data already in flight.
- **Out-of-range read:** if `ar_address` ≥ `DEPTH`, the request still returns `r_valid`=1 with `r_data`=0, and `err_addr` is set.
- **Same-cycle write and read, same in-range address:**
  - "NEW": returns `w_data` (bypass).
  - "OLD": returns the content before the write.
  - Different addresses: the two ports are independent.
- **`err_addr`:** set on the edge where the bad address is sampled. It is cleared only by reset; a simultaneous good access does not clear it.
- **Power-of-two `DEPTH`:** no address can be out of range, so `err_addr` stays 0.
- **Reset (`reset`=0, asynchronous):**
  - Immediately: `r_valid`=0, `r_data`=0, `err_addr`=0.
  - All in-flight read requests are discarded, and the pipeline valid bits are cleared.
  - Memory contents are not cleared; they are undefined after power-up and preserved across reset.
  - While reset is held, writes and read requests are ignored.
- **Reset deassertion:** the first request can be accepted on the first rising edge after `reset` goes high.
- **`r_data` between pulses:** holds the value of the most recent returned read while `r_valid`=0.

## Timing
- Request accepted at edge N → `r_valid`=1 for exactly the cycle following edge N+`READ_LATENCY`-1, i.e. visible `READ_LATENCY` cycles after the request was presented.
- Throughput: one read and one write per cycle. N consecutive requests give N consecutive `r_valid` cycles, in request order.
- A write at edge N is visible to a read accepted at edge N+1 in both modes. It is visible at edge N only in "NEW" mode.
- `err_addr` rises the cycle after the offending edge, i.e. it is registered.
- No combinational path from any input to any output.

## Test plan
- **Reset values:** hold `reset`=0 for 3 cycles with random inputs → `r_valid`=0, `r_data`=0, `err_addr`=0 throughout; no `r_valid` pulse after release without a request.
- **Basic write/read:** write addr 5 = 0x2A5, then read addr 5 the next cycle → single `r_valid` pulse exactly `READ_LATENCY` cycles later with `r_data`=0x2A5. Repeat for `READ_LATENCY` = 1, 2, 3.
- **Streaming:** write 0x10–0x13 to addrs 0–3, then 4 back-to-back reads of 0–3 → 4 consecutive `r_valid` cycles with data 0x10, 0x11, 0x12, 0x13.
- **Read-during-write collision:** addr 7 holds 0x001; same-cycle write 0x3FF and read addr 7 → returns 0x3FF with "NEW", 0x001 with "OLD"; a subsequent read returns 0x3FF in both modes.
- **Out-of-range write:** `DEPTH`=10, write addr 12 = 0x155 → `err_addr`=1 next cycle and stays 1.
- **Out-of-range read:** `DEPTH`=10, read addr 12 → `r_valid` pulse with `r_data`=0.
- **Reset mid-flight:** `READ_LATENCY`=3; issue reads at two consecutive edges, then assert `reset` one cycle later → no `r_valid` pulse ever emerges; memory still holds the previously written values when read after release.

Source files
------------

// File: rtl/sdp_ram_responder_if.sv
// Write / read-request / read-return bus between the delay-line controller and the RAM responder.
// Strobes are valid-only: w_valid and ar_valid are accepted on every rising edge they are high; r_valid pulses once per accepted read.
interface sdp_ram_responder_if #(
   parameter int WIDTH = 10,
   parameter int AW    = 6
);
   logic             w_valid;
   logic [AW-1:0]    w_address;
   logic [WIDTH-1:0] w_data;
   logic             ar_valid;
   logic [AW-1:0]    ar_address;
   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             err_addr;

   modport master (
      output w_valid, w_address, w_data, ar_valid, ar_address,
      input  r_valid, r_data, err_addr
   );

   modport slave (
      input  w_valid, w_address, w_data, ar_valid, ar_address,
      output r_valid, r_data, err_addr
   );
endinterface

// File: rtl/sdp_ram_responder.sv
// Simple-dual-port RAM with a fixed-latency read pipeline, selectable read-during-write
// result and a sticky out-of-range address flag.
module sdp_ram_responder #(
   parameter int    WIDTH        = 10,
   parameter int    DEPTH        = 64,
   parameter int    READ_LATENCY = 1,
   parameter string RDW_MODE     = "NEW"
) (
   input logic                 clk,
   input logic                 reset,
   sdp_ram_responder_if.slave  bus
);
   localparam int AW      = $clog2(DEPTH);
   localparam bit POW2    = (DEPTH == (1 << AW));
   localparam bit RDW_NEW = (RDW_MODE == "NEW");

   logic [WIDTH-1:0] mem [DEPTH];
   logic [READ_LATENCY-1:0] vld;
   logic [WIDTH-1:0] dat [READ_LATENCY];
   logic             err;
   logic             w_oor;
   logic             ar_oor;
   logic             hit;
   logic [WIDTH-1:0] rd_word;

   // A power-of-two depth covers every address code, so nothing can be out of range.
   always_comb begin
      w_oor  = 1'b0;
      ar_oor = 1'b0;
      if (!POW2) begin
         w_oor  = ({1'b0, bus.w_address}  >= (AW+1)'(DEPTH));
         ar_oor = ({1'b0, bus.ar_address} >= (AW+1)'(DEPTH));
      end
   end

   always_comb begin
      hit     = bus.w_valid && !w_oor && (bus.w_address == bus.ar_address);
      rd_word = '0;
      if (!ar_oor) begin
         if (RDW_NEW && hit) rd_word = bus.w_data;
         else                rd_word = mem[bus.ar_address];
      end
   end

   // Array content is never cleared; reset only blocks writes while it is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
      end else if (bus.w_valid && !w_oor) begin
         mem[bus.w_address] <= bus.w_data;
      end
   end

   // Data stages only advance behind a valid bit, so the last stage holds the most recent return.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         vld <= '0;
         err <= 1'b0;
         for (int i = 0; i < READ_LATENCY; i++) dat[i] <= '0;
      end else begin
         vld[0] <= bus.ar_valid;
         if (bus.ar_valid) dat[0] <= rd_word;
         for (int i = 1; i < READ_LATENCY; i++) begin
            vld[i] <= vld[i-1];
            if (vld[i-1]) dat[i] <= dat[i-1];
         end
         if ((bus.w_valid && w_oor) || (bus.ar_valid && ar_oor)) err <= 1'b1;
      end
   end

   assign bus.r_valid  = vld[READ_LATENCY-1];
   assign bus.r_data   = dat[READ_LATENCY-1];
   assign bus.err_addr = err;
endmodule

// File: tb/tb_sdp_ram_responder.sv
// Three responder configurations driven by one shared stimulus stream, each with its own
// reference memory and expected-return queue.
module tb_sdp_ram_responder;
   localparam int N = 3;
   localparam int DEP [N] = '{64, 10, 16};
   localparam int LAT [N] = '{1, 2, 3};
   localparam bit NEWM [N] = '{1'b1, 1'b0, 1'b1};

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       w_valid = 1'b0;
   logic [3:0] w_address = '0;
   logic [9:0] w_data = '0;
   logic       ar_valid = 1'b0;
   logic [3:0] ar_address = '0;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;

   logic [9:0] exp_q [N][$];
   int         stamp_q [N][$];
   logic [9:0] mdl [N][16];

   logic       rv  [N];
   logic [9:0] rd  [N];
   logic       err [N];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sdp_ram_responder_if #(.WIDTH(10), .AW(6)) if_a ();
   sdp_ram_responder_if #(.WIDTH(10), .AW(4)) if_b ();
   sdp_ram_responder_if #(.WIDTH(10), .AW(4)) if_c ();

   assign if_a.w_valid = w_valid;  assign if_a.w_address = {2'b00, w_address};
   assign if_a.w_data = w_data;    assign if_a.ar_valid = ar_valid;
   assign if_a.ar_address = {2'b00, ar_address};
   assign if_b.w_valid = w_valid;  assign if_b.w_address = w_address;
   assign if_b.w_data = w_data;    assign if_b.ar_valid = ar_valid;
   assign if_b.ar_address = ar_address;
   assign if_c.w_valid = w_valid;  assign if_c.w_address = w_address;
   assign if_c.w_data = w_data;    assign if_c.ar_valid = ar_valid;
   assign if_c.ar_address = ar_address;

   assign rv[0] = if_a.r_valid; assign rd[0] = if_a.r_data; assign err[0] = if_a.err_addr;
   assign rv[1] = if_b.r_valid; assign rd[1] = if_b.r_data; assign err[1] = if_b.err_addr;
   assign rv[2] = if_c.r_valid; assign rd[2] = if_c.r_data; assign err[2] = if_c.err_addr;

   sdp_ram_responder #(.WIDTH(10), .DEPTH(64), .READ_LATENCY(1), .RDW_MODE("NEW"))
      u_a (.clk(clk), .reset(reset), .bus(if_a));
   sdp_ram_responder #(.WIDTH(10), .DEPTH(10), .READ_LATENCY(2), .RDW_MODE("OLD"))
      u_b (.clk(clk), .reset(reset), .bus(if_b));
   sdp_ram_responder #(.WIDTH(10), .DEPTH(16), .READ_LATENCY(3), .RDW_MODE("NEW"))
      u_c (.clk(clk), .reset(reset), .bus(if_c));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin : monitor
      logic [9:0] d;
      int s;
      for (int k = 0; k < N; k++) begin
         if (rv[k] === 1'b1) begin
            if (exp_q[k].size() == 0) begin
               check($sformatf("spurious_r_valid_dut%0d", k), 32'd1, 32'd0);
            end else begin
               d = exp_q[k].pop_front();
               s = stamp_q[k].pop_front();
               check($sformatf("r_data_dut%0d", k), 32'(rd[k]), 32'(d));
               check($sformatf("latency_dut%0d", k), 32'(cyc - s), 32'(LAT[k]));
            end
         end
      end
   end

   task automatic step(input logic wv, input logic [3:0] wa, input logic [9:0] wd,
                       input logic rv_i, input logic [3:0] ra);
      logic [9:0] e;
      @(negedge clk);
      w_valid = wv; w_address = wa; w_data = wd; ar_valid = rv_i; ar_address = ra;
      if (reset) begin
         for (int k = 0; k < N; k++) begin
            if (rv_i) begin
               if (int'(ra) >= DEP[k])                    e = '0;
               else if (NEWM[k] && wv && (wa == ra))      e = wd;
               else                                       e = mdl[k][ra];
               exp_q[k].push_back(e);
               stamp_q[k].push_back(cyc);
            end
            if (wv && int'(wa) < DEP[k]) mdl[k][wa] = wd;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b0;
      for (int k = 0; k < N; k++) begin
         exp_q[k].delete();
         stamp_q[k].delete();
      end
      #1;
      for (int k = 0; k < N; k++) begin
         check($sformatf("rst_now_r_valid_dut%0d", k), 32'(rv[k]), 32'd0);
         check($sformatf("rst_now_r_data_dut%0d", k), 32'(rd[k]), 32'd0);
         check($sformatf("rst_now_err_dut%0d", k), 32'(err[k]), 32'd0);
      end
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         w_valid = 1'($urandom_range(0, 1));
         w_address = 4'($urandom_range(0, 15));
         w_data = 10'($urandom);
         ar_valid = 1'($urandom_range(0, 1));
         ar_address = 4'($urandom_range(0, 15));
         for (int k = 0; k < N; k++) begin
            check($sformatf("rst_hold_r_valid_dut%0d", k), 32'(rv[k]), 32'd0);
            check($sformatf("rst_hold_err_dut%0d", k), 32'(err[k]), 32'd0);
         end
      end
      @(negedge clk);
      w_valid = 1'b0; ar_valid = 1'b0;
      #2 reset = 1'b1;
   endtask

   task automatic check_err(input string tag, input logic ea, input logic eb, input logic ec);
      check({tag, "_dut0"}, 32'(err[0]), 32'(ea));
      check({tag, "_dut1"}, 32'(err[1]), 32'(eb));
      check({tag, "_dut2"}, 32'(err[2]), 32'(ec));
   endtask

   initial begin
      do_reset();
      repeat (4) step(0, 0, 0, 0, 0);

      // Fill every address code; depth-10 instance sees codes 10..15 as out of range.
      for (int a = 0; a < 16; a++) step(1, 4'(a), 10'($urandom), 0, 0);
      step(0, 0, 0, 0, 0);
      check_err("err_after_preload", 1'b0, 1'b1, 1'b0);
      do_reset();
      check_err("err_after_reset", 1'b0, 1'b0, 1'b0);
      repeat (4) step(0, 0, 0, 0, 0);

      step(1, 5, 10'h2A5, 0, 0);
      step(0, 0, 0, 1, 5);
      repeat (4) step(0, 0, 0, 0, 0);

      for (int a = 0; a < 4; a++) step(1, 4'(a), 10'(16 + a), 0, 0);
      for (int a = 0; a < 4; a++) step(0, 0, 0, 1, 4'(a));
      repeat (4) step(0, 0, 0, 0, 0);

      step(1, 7, 10'h001, 0, 0);
      step(1, 7, 10'h3FF, 1, 7);
      step(0, 0, 0, 1, 7);
      step(1, 3, 10'h0AA, 1, 2);
      step(0, 0, 0, 1, 4);
      step(1, 4, 10'h123, 0, 0);
      step(0, 0, 0, 1, 4);
      step(0, 0, 0, 1, 3);
      repeat (4) step(0, 0, 0, 0, 0);

      for (int i = 0; i < 150; i++)
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 10'($urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)));
      repeat (4) step(0, 0, 0, 0, 0);
      check_err("err_in_range_traffic", 1'b0, 1'b0, 1'b0);

      step(1, 12, 10'h155, 0, 0);
      step(0, 0, 0, 0, 0);
      check_err("err_oor_write", 1'b0, 1'b1, 1'b0);
      step(1, 2, 10'h0CC, 1, 2);
      step(0, 0, 0, 1, 12);
      step(0, 0, 0, 1, 11);
      repeat (4) step(0, 0, 0, 0, 0);
      check_err("err_sticky", 1'b0, 1'b1, 1'b0);

      step(1, 1, 10'h2B1, 0, 0);
      step(1, 6, 10'h1C6, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 6);
      do_reset();
      repeat (6) step(0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 6);
      step(0, 0, 0, 1, 12);
      repeat (6) step(0, 0, 0, 0, 0);

      for (int k = 0; k < N; k++)
         check($sformatf("queue_drained_dut%0d", k), 32'(exp_q[k].size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
